procyon_ifq_wb: RTL

// Wishbone-backed instruction fetch queue feeding the core's ifq interface (i_ifq_full/i_ifq_fill_*).

---
 rtl/procyon_ifq_wb_if.sv | 26 ++
 rtl/procyon_ifq_wb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/procyon_ifq_wb_if.sv
// Wishbone bundle between the instruction fetch queue (master) and a memory-side slave.
// Read-only burst usage: the master drives address/controls, the slave returns ack/data.
interface procyon_ifq_wb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    wb_cyc;
   logic                    wb_stb;
   logic                    wb_we;
   logic [2:0]              wb_cti;
   logic [1:0]              wb_bte;
   logic [DATA_WIDTH/8-1:0] wb_sel;
   logic [ADDR_WIDTH-1:0]   wb_addr;
   logic                    wb_ack;
   logic [DATA_WIDTH-1:0]   wb_data;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_cti, wb_bte, wb_sel, wb_addr,
      input  wb_ack, wb_data
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_cti, wb_bte, wb_sel, wb_addr,
      output wb_ack, wb_data
   );
endinterface

// File: rtl/procyon_ifq_wb.sv
// Instruction fetch queue: buffers line-fill requests and fetches each line with one
// Wishbone incrementing burst, returning the whole line as a single-cycle fill pulse.
// Handshake: a beat completes on any cycle where stb=1 and ack=1; stb/addr/cti hold until then.
module procyon_ifq_wb #(
   parameter int OPTN_ADDR_WIDTH    = 32,
   parameter int OPTN_IC_LINE_SIZE  = 32,
   parameter int OPTN_IFQ_DEPTH     = 2,
   parameter int OPTN_WB_DATA_WIDTH = 32,
   parameter int OPTN_WB_ADDR_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           n_rst,
   input  logic                           i_flush,
   input  logic                           i_alloc_en,
   input  logic [OPTN_ADDR_WIDTH-1:0]     i_alloc_addr,
   output logic                           o_full,
   output logic                           o_fill_en,
   output logic [OPTN_ADDR_WIDTH-1:0]     o_fill_addr,
   output logic [OPTN_IC_LINE_SIZE*8-1:0] o_fill_data,
   output logic [1:0]                     o_dbg_state,
   procyon_ifq_wb_if.master               wb
);
   localparam int WB_DATA_SIZE = OPTN_WB_DATA_WIDTH / 8;
   localparam int BEATS        = OPTN_IC_LINE_SIZE / WB_DATA_SIZE;
   localparam int BW           = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int QW           = $clog2(OPTN_IFQ_DEPTH);
   localparam int CW           = QW + 1;
   localparam int LW           = OPTN_IC_LINE_SIZE * 8;
   localparam logic [OPTN_ADDR_WIDTH-1:0] OFFSET_MASK = OPTN_ADDR_WIDTH'(OPTN_IC_LINE_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   state_e                      state_q, state_d;
   logic [BW-1:0]               beat_q, beat_d;
   logic [OPTN_ADDR_WIDTH-1:0]  line_addr_q, line_addr_d;
   logic [OPTN_WB_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
   logic                        cyc_q, cyc_d;
   logic [2:0]                  cti_q, cti_d;
   logic [LW-1:0]               line_q, line_d;
   logic                        fill_en_q, fill_en_d;
   logic [OPTN_ADDR_WIDTH-1:0]  fill_addr_q, fill_addr_d;
   logic [LW-1:0]               fill_data_q, fill_data_d;
   logic [QW-1:0]               head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]               count_q, count_d;
   logic [OPTN_ADDR_WIDTH-1:0]  qaddr_q [OPTN_IFQ_DEPTH];
   logic [OPTN_ADDR_WIDTH-1:0]  qaddr_d [OPTN_IFQ_DEPTH];
   logic [OPTN_IFQ_DEPTH-1:0]   qvld_q, qvld_d;
   logic [OPTN_ADDR_WIDTH-1:0]  alloc_line;
   logic                        dup, enq, deq;

   assign alloc_line = i_alloc_addr & ~OFFSET_MASK;
   assign o_full     = (count_q == CW'(OPTN_IFQ_DEPTH));

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      line_addr_d = line_addr_q;
      wb_addr_d   = wb_addr_q;
      cyc_d       = cyc_q;
      cti_d       = cti_q;
      line_d      = line_q;
      fill_en_d   = 1'b0;
      fill_addr_d = fill_addr_q;
      fill_data_d = fill_data_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      qaddr_d     = qaddr_q;
      qvld_d      = qvld_q;
      dup         = 1'b0;
      deq         = 1'b0;

      // The in-flight line stays queued until DONE, but check it directly as well.
      for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
         if (qvld_q[i] && (qaddr_q[i] == alloc_line)) dup = 1'b1;
      end
      if ((state_q != ST_IDLE) && (line_addr_q == alloc_line)) dup = 1'b1;
      enq = i_alloc_en && !o_full && !dup && !i_flush;

      case (state_q)
         ST_IDLE: begin
            if ((count_q != '0) && !i_flush) begin
               line_addr_d = qaddr_q[head_q];
               wb_addr_d   = OPTN_WB_ADDR_WIDTH'(qaddr_q[head_q]);
               beat_d      = '0;
               cyc_d       = 1'b1;
               cti_d       = (BEATS == 1) ? 3'b111 : 3'b010;
               state_d     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (i_flush) begin
               cyc_d   = 1'b0;
               beat_d  = '0;
               state_d = ST_IDLE;
            end else if (wb.wb_ack) begin
               for (int k = 0; k < BEATS; k++) begin
                  if (beat_q == BW'(k))
                     line_d[k*OPTN_WB_DATA_WIDTH +: OPTN_WB_DATA_WIDTH] = wb.wb_data;
               end
               if (beat_q == BW'(BEATS - 1)) begin
                  cyc_d   = 1'b0;
                  beat_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  beat_d    = beat_q + 1'b1;
                  wb_addr_d = wb_addr_q + OPTN_WB_ADDR_WIDTH'(WB_DATA_SIZE);
                  cti_d     = (beat_d == BW'(BEATS - 1)) ? 3'b111 : 3'b010;
               end
            end
         end
         ST_DONE: begin
            deq     = 1'b1;
            state_d = ST_IDLE;
            if (!i_flush) begin
               fill_en_d   = 1'b1;
               fill_addr_d = line_addr_q;
               fill_data_d = line_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (i_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         qvld_d  = '0;
      end else begin
         if (deq) begin
            qvld_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
         end
         if (enq) begin
            qaddr_d[tail_q] = alloc_line;
            qvld_d[tail_q]  = 1'b1;
            tail_d          = tail_q + 1'b1;
         end
         count_d = count_q + CW'(enq) - CW'(deq);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         line_addr_q <= '0;
         wb_addr_q   <= '0;
         cyc_q       <= 1'b0;
         cti_q       <= 3'b000;
         line_q      <= '0;
         fill_en_q   <= 1'b0;
         fill_addr_q <= '0;
         fill_data_q <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         qvld_q      <= '0;
         for (int i = 0; i < OPTN_IFQ_DEPTH; i++) qaddr_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         line_addr_q <= line_addr_d;
         wb_addr_q   <= wb_addr_d;
         cyc_q       <= cyc_d;
         cti_q       <= cti_d;
         line_q      <= line_d;
         fill_en_q   <= fill_en_d;
         fill_addr_q <= fill_addr_d;
         fill_data_q <= fill_data_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         qvld_q      <= qvld_d;
         qaddr_q     <= qaddr_d;
      end
   end

   assign o_fill_en   = fill_en_q;
   assign o_fill_addr = fill_addr_q;
   assign o_fill_data = fill_data_q;
   assign o_dbg_state = state_q;

   assign wb.wb_cyc  = cyc_q;
   assign wb.wb_stb  = cyc_q;
   assign wb.wb_we   = 1'b0;
   assign wb.wb_cti  = cti_q;
   assign wb.wb_bte  = 2'b00;
   assign wb.wb_sel  = '1;
   assign wb.wb_addr = wb_addr_q;
endmodule
